missle_launcher: RTL and testbench



---
 rtl/game_pkg.sv | 26 ++
 rtl/lfsr16.sv | 34 +++
 rtl/missle_launcher.sv | 162 ++++++++++++++++
 tb/tb_missle_launcher.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types and constants for the sprite pipeline.
// Imported by the launcher and the reusable LFSR.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COOLDOWN,
    SELECT,
    FIRE,
    FLIGHT
  } launcher_state_t;

  localparam logic [9:0]  SCREEN_W    = 10'd640;
  localparam logic [9:0]  SCREEN_H    = 10'd480;
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  function automatic logic [7:0] sat_add8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR advancing every clock.
// Reloads the seed if it ever reaches the lock-up value 0.
module lfsr16
  import game_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_d;
  logic [15:0] value_q;

  always_comb begin
    if (value_q == 16'h0) begin
      value_d = seed;
    end else begin
      value_d = (value_q >> 1)
              ^ (value_q[0] ? LFSR16_TAPS : 16'h0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      value_q <= seed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/missle_launcher.sv
// Enemy missile scheduler: random inter-shot gaps,
// round-robin choice among live shooters, one-cycle launch.
module missle_launcher
  import game_pkg::*;
#(
  parameter int          NUM_SHOOTERS      = 4,
  parameter logic [7:0]  MIN_GAP_FRAMES    = 8'd30,
  parameter logic [7:0]  GAP_MASK          = 8'h3F,
  parameter logic [7:0]  MAX_FLIGHT_FRAMES = 8'd120,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic                      enable,
  input  logic [NUM_SHOOTERS-1:0]   shooter_alive,
  input  logic [10*NUM_SHOOTERS-1:0] shooter_x,
  input  logic [10*NUM_SHOOTERS-1:0] shooter_y,
  input  logic                      explored,
  output logic                      launch,
  output logic [9:0]                start_x,
  output logic [9:0]                start_y,
  output logic [2:0]                shooter_sel,
  output logic                      busy
);

  launcher_state_t state_d, state_q;
  logic [7:0]  cnt_d, cnt_q;
  logic [2:0]  ptr_d, ptr_q;
  logic [3:0]  scan_d, scan_q;
  logic        seen_d, seen_q;
  logic [9:0]  sx_d, sx_q;
  logic [9:0]  sy_d, sy_q;
  logic [2:0]  sel_d, sel_q;
  logic        launch_d, launch_q;
  logic        busy_d, busy_q;
  logic        fc_q, tick_q;

  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic [7:0]  gap;
  logic [2:0]  ptr_nxt;
  logic [7:0]  alive8;
  logic [79:0] x_pad;
  logic [79:0] y_pad;

  lfsr16 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .seed  (LFSR_SEED),
    .value (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:8];
  assign gap     = sat_add8(MIN_GAP_FRAMES, lfsr[7:0] & GAP_MASK);
  assign ptr_nxt = (ptr_q == 3'(NUM_SHOOTERS - 1)) ? 3'd0 : ptr_q + 3'd1;
  assign alive8  = 8'(shooter_alive);
  assign x_pad   = 80'(shooter_x);
  assign y_pad   = 80'(shooter_y);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    scan_d  = scan_q;
    seen_d  = seen_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sel_d   = sel_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|shooter_alive) begin
            state_d = COOLDOWN;
            cnt_d   = gap;
          end
        end
        COOLDOWN: begin
          if (cnt_q == 8'd0) begin
            state_d = SELECT;
            scan_d  = 4'd0;
          end else if (tick_q) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        SELECT: begin
          ptr_d = ptr_nxt;
          if (alive8[ptr_q]) begin
            sx_d    = x_pad[int'(ptr_q)*10 +: 10];
            sy_d    = y_pad[int'(ptr_q)*10 +: 10];
            sel_d   = ptr_q;
            state_d = FIRE;
          end else begin
            scan_d = scan_q + 4'd1;
            if (scan_q + 4'd1 == 4'(NUM_SHOOTERS)) begin
              state_d = IDLE;
            end
          end
        end
        FIRE: begin
          state_d = FLIGHT;
          cnt_d   = MAX_FLIGHT_FRAMES;
          seen_d  = 1'b0;
        end
        FLIGHT: begin
          // a tick must pass first so a stale explored is ignored
          if (seen_q && (explored || cnt_q == 8'd0)) begin
            state_d = COOLDOWN;
            cnt_d   = gap;
          end else if (tick_q) begin
            seen_d = 1'b1;
            if (cnt_q != 8'd0) begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    launch_d = (state_d == FIRE);
    busy_d   = (state_d == FIRE) || (state_d == FLIGHT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      ptr_q    <= 3'd0;
      scan_q   <= 4'd0;
      seen_q   <= 1'b0;
      sx_q     <= 10'd0;
      sy_q     <= 10'd0;
      sel_q    <= 3'd0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      fc_q     <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      scan_q   <= scan_d;
      seen_q   <= seen_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      sel_q    <= sel_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      fc_q     <= frame_clk;
      tick_q   <= frame_clk & ~fc_q;
    end
  end

  assign launch      = launch_q;
  assign start_x     = sx_q;
  assign start_y     = sy_q;
  assign shooter_sel = sel_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_missle_launcher.sv
// Randomized bench for missle_launcher against a
// transaction-level model of gaps, flights and round-robin.
module tb_missle_launcher;

  localparam int N = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_clk = 1'b0;
  logic enable = 1'b0;
  logic explored = 1'b0;
  logic [N-1:0] alive = '0;
  logic [10*N-1:0] sx = '0;
  logic [10*N-1:0] sy = '0;
  logic launch;
  logic [9:0] start_x, start_y;
  logic [2:0] shooter_sel;
  logic busy;

  missle_launcher dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .enable        (enable),
    .shooter_alive (alive),
    .shooter_x     (sx),
    .shooter_y     (sy),
    .explored      (explored),
    .launch        (launch),
    .start_x       (start_x),
    .start_y       (start_y),
    .shooter_sel   (shooter_sel),
    .busy          (busy)
  );

  always #10 Clk = ~Clk;

  int fc_cnt = 0;
  initial begin
    forever begin
      @(negedge Clk);
      frame_clk = (fc_cnt < 2);
      fc_cnt = (fc_cnt == 11) ? 0 : fc_cnt + 1;
    end
  end

  // Reference LFSR and frame tick
  logic [15:0] m_lfsr;
  logic m_fc, m_tick;
  always @(posedge Clk) begin
    if (Reset) begin
      m_lfsr <= 16'hACE1;
      m_fc   <= 1'b0;
      m_tick <= 1'b0;
    end else begin
      m_fc   <= frame_clk;
      m_tick <= frame_clk & ~m_fc;
      if (m_lfsr == 16'h0)
        m_lfsr <= 16'hACE1;
      else
        m_lfsr <= (m_lfsr / 2) ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_launch = 0;
  int gap_ticks, gap_exp, fl_ticks, fl_exp;
  int mptr = 0;
  bit gap_on = 0, fl_on = 0, fl_skip = 0;
  bit prev_busy = 0, prev_launch = 0;
  logic [15:0] lfsr_prev = 16'hACE1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gapf(logic [15:0] v);
    int g;
    g = 30 + int'(v[7:0] & 8'h3F);
    return (g > 255) ? 255 : g;
  endfunction

  function automatic int rr_pick();
    for (int i = 0; i < N; i++) begin
      if (alive[(mptr + i) % N]) return (mptr + i) % N;
    end
    return -1;
  endfunction

  task automatic observe();
    int idx;
    if (launch === 1'b1) begin
      n_launch++;
      idx = rr_pick();
      if (idx < 0) begin
        check("launch_no_alive", 1, 0);
        idx = 0;
      end
      check("sel", shooter_sel, idx);
      check("start_x", start_x, sx[idx*10 +: 10]);
      check("start_y", start_y, sy[idx*10 +: 10]);
      check("busy_fire", busy, 1);
      if (gap_on) check("gap_ticks", gap_ticks, gap_exp);
      gap_on = 0;
      fl_on = 1;
      fl_ticks = 0;
      fl_skip = 1;
      mptr = (idx + 1) % N;
    end
    if (prev_launch) check("launch_width", launch, 0);
    if (prev_busy && busy === 1'b0) begin
      if (enable && !Reset) begin
        if (fl_on && fl_exp >= 0) check("flight_ticks", fl_ticks, fl_exp);
        gap_on = 1;
        gap_ticks = 0;
        gap_exp = gapf(lfsr_prev);
      end
      fl_on = 0;
    end
    if (gap_on && m_tick) gap_ticks++;
    if (fl_on) begin
      if (fl_skip) fl_skip = 0;
      else if (m_tick) fl_ticks++;
    end
    prev_busy = (busy === 1'b1);
    prev_launch = (launch === 1'b1);
    lfsr_prev = m_lfsr;
  endtask

  task automatic cyc();
    @(negedge Clk);
    observe();
  endtask

  // DUT leaves IDLE at the next edge using the current LFSR value
  task automatic arm();
    gap_on = 1;
    gap_ticks = 0;
    gap_exp = gapf(m_lfsr);
  endtask

  task automatic wait_launch();
    int n0, k;
    n0 = n_launch;
    k = 0;
    while (n_launch == n0 && k < 4000) begin
      cyc();
      k++;
    end
    if (n_launch == n0) check("launch_timeout", 0, 1);
  endtask

  task automatic wait_idle_busy();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      cyc();
      k++;
    end
    check("flight_exit", busy, 0);
  endtask

  task automatic flight_pulse(int k);
    int t;
    fl_exp = k;
    t = 0;
    while (fl_on && fl_ticks < k && t < 3000) begin
      cyc();
      t++;
    end
    explored = 1'b1;
    cyc();
    explored = 1'b0;
    check("pulse_exit", busy, 0);
  endtask

  task automatic rand_slots();
    for (int i = 0; i < N; i++) begin
      sx[i*10 +: 10] = 10'($urandom_range(0, 639));
      sy[i*10 +: 10] = 10'($urandom_range(0, 479));
    end
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_launch"}, launch, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sel"}, shooter_sel, 0);
    check({tag, "_x"}, start_x, 0);
    check({tag, "_y"}, start_y, 0);
  endtask

  initial begin
    int n0, t;
    Reset = 1'b1;
    repeat (3) cyc();
    check_reset_outs("reset");
    Reset = 1'b0;
    cyc();

    rand_slots();
    sx[9:0] = 10'd100;
    sy[9:0] = 10'd40;
    alive = 4'b1111;
    enable = 1'b1;
    arm();
    wait_launch();
    check("first_sel", shooter_sel, 0);
    flight_pulse(5);

    alive = 4'b1010;
    repeat (3) begin
      wait_launch();
      flight_pulse(5);
    end

    alive = 4'b0001;
    explored = 1'b1;
    repeat (2) begin
      fl_exp = 1;
      wait_launch();
      wait_idle_busy();
    end
    explored = 1'b0;

    fl_exp = 120;
    wait_launch();
    wait_idle_busy();
    repeat (5) cyc();
    check("busy_cooldown", busy, 0);

    alive = 4'b0000;
    n0 = n_launch;
    t = 0;
    while (gap_on && gap_ticks < gap_exp && t < 3000) begin
      cyc();
      t++;
    end
    repeat (10) cyc();
    check("dead_no_launch", n_launch, n0);
    check("dead_busy", busy, 0);
    alive = 4'b0100;
    arm();
    wait_launch();
    check("restart_sel", shooter_sel, 2);
    flight_pulse(3);

    wait_launch();
    Reset = 1'b1;
    cyc();
    check_reset_outs("midrst");
    gap_on = 0;
    fl_on = 0;
    mptr = 0;
    Reset = 1'b0;
    arm();
    wait_launch();
    repeat (3) cyc();
    enable = 1'b0;
    cyc();
    check("endrop_busy", busy, 0);
    n0 = n_launch;
    repeat (600) cyc();
    check("endrop_no_launch", n_launch, n0);

    for (int r = 0; r < 6; r++) begin
      alive = 4'($urandom_range(1, 15));
      rand_slots();
      enable = 1'b1;
      arm();
      repeat (2) begin
        wait_launch();
        flight_pulse($urandom_range(2, 8));
      end
      enable = 1'b0;
      gap_on = 0;
      repeat (3) cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
